// File: rtl/dpram_pkg.sv
// Shared types and helpers for the dual-port RAM controller and its storage core.
package dpram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    function automatic int bew_of(input int dw);
        return dw / 8;
    endfunction

    // One byte lane of a byte-enabled write: new data where enabled, old data elsewhere.
    function automatic logic [7:0] be_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       be);
        return be ? new_b : old_b;
    endfunction

endpackage

// File: rtl/dual_port_ram_ctrl_if.sv
// Request/response bundle between a RAM client (master) and dual_port_ram_ctrl (slave).
interface dual_port_ram_ctrl_if #(
    parameter int DPW = 10,
    parameter int DW  = 32
);
    logic            init_req;
    logic            init_busy;
    logic            init_done;

    logic            rea;
    logic [DPW-1:0]  addra;
    logic [DW-1:0]   douta;
    logic            valida;

    logic            web;
    logic [DW/8-1:0] beb;
    logic [DPW-1:0]  addrb;
    logic [DW-1:0]   dinb;
    logic            reb;
    logic [DW-1:0]   doutb;
    logic            validb;

    modport master (
        output init_req, rea, addra, web, beb, addrb, dinb, reb,
        input  init_busy, init_done, douta, valida, doutb, validb
    );

    modport slave (
        input  init_req, rea, addra, web, beb, addrb, dinb, reb,
        output init_busy, init_done, douta, valida, doutb, validb
    );
endinterface

// File: rtl/dual_port_ram_core.sv
// Storage array with one byte-enabled write port and two read-first registered read ports.
module dual_port_ram_core
    import dpram_pkg::*;
#(
    parameter int DPW = 10,
    parameter int DW  = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_we,
    input  logic [DW/8-1:0] i_be,
    input  logic [DPW-1:0]  i_waddr,
    input  logic [DW-1:0]   i_wdata,
    input  logic            i_rea,
    input  logic [DPW-1:0]  i_addra,
    input  logic            i_reb,
    input  logic [DPW-1:0]  i_addrb,
    output logic [DW-1:0]   o_qa,
    output logic [DW-1:0]   o_qb
);
    localparam int BEW   = bew_of(DW);
    localparam int DEPTH = 2 ** DPW;

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_qa;
    logic [DW-1:0] r_qb;

    // The array has no reset so it can map onto block RAM; the clear engine zeroes it.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int k = 0; k < BEW; k++) begin
                if (i_be[k]) begin
                    r_mem[i_waddr][8*k +: 8] <= i_wdata[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_qa <= '0;
            r_qb <= '0;
        end else begin
            if (i_rea) begin
                r_qa <= r_mem[i_addra];
            end
            if (i_reb) begin
                r_qb <= r_mem[i_addrb];
            end
        end
    end

    assign o_qa = r_qa;
    assign o_qb = r_qb;

endmodule

// File: rtl/dual_port_ram_ctrl.sv
// Dual-port RAM controller: clear engine FSM, A-side write forwarding, optional
// output register and read-valid pipeline around dual_port_ram_core.
module dual_port_ram_ctrl
    import dpram_pkg::*;
#(
    parameter int DPW  = 10,
    parameter int DW   = 32,
    parameter int OREG = 0,
    parameter int FWD  = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    dual_port_ram_ctrl_if.slave bus_if
);
    localparam int BEW = bew_of(DW);
    localparam logic [DPW-1:0] LAST_ADDR = '1;

    generate
        if ((DW % 8) != 0 || DW < 8) begin : g_bad_dw
            $error("dual_port_ram_ctrl: DW (%0d) must be a non-zero multiple of 8", DW);
        end
    endgenerate

    state_t         r_state;
    state_t         w_state_nxt;
    logic [DPW-1:0] r_clr_addr;
    logic [DPW-1:0] w_clr_addr_nxt;
    logic           r_init_done;
    logic           w_init_done_nxt;
    logic           w_ready;

    logic           w_we;
    logic [BEW-1:0] w_be;
    logic [DPW-1:0] w_waddr;
    logic [DW-1:0]  w_wdata;
    logic           w_rea;
    logic           w_reb;
    logic [DW-1:0]  w_qa;
    logic [DW-1:0]  w_qb;

    logic           w_fwd_hit;
    logic           r_fwd_hit;
    logic [DW-1:0]  r_fwd_data;
    logic [BEW-1:0] r_fwd_be;
    logic [DW-1:0]  w_qa_merged;
    logic [DW-1:0]  w_douta_s1;
    logic           r_valida1;
    logic           r_validb1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_CLEAR;
            r_clr_addr  <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_clr_addr  <= w_clr_addr_nxt;
            r_init_done <= w_init_done_nxt;
        end
    end

    // The done pulse is raised on the edge that writes the last word, so it lines up with the first ready cycle.
    always_comb begin
        w_state_nxt     = r_state;
        w_clr_addr_nxt  = r_clr_addr;
        w_init_done_nxt = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clr_addr_nxt = r_clr_addr + 1'b1;
                if (r_clr_addr == LAST_ADDR) begin
                    w_state_nxt     = ST_READY;
                    w_init_done_nxt = 1'b1;
                end
            end
            ST_READY: begin
                if (bus_if.init_req) begin
                    w_state_nxt    = ST_CLEAR;
                    w_clr_addr_nxt = '0;
                end
            end
            default: begin
                w_state_nxt    = ST_CLEAR;
                w_clr_addr_nxt = '0;
            end
        endcase
    end

    assign w_ready = (r_state == ST_READY);

    assign w_we    = w_ready ? bus_if.web   : 1'b1;
    assign w_be    = w_ready ? bus_if.beb   : {BEW{1'b1}};
    assign w_waddr = w_ready ? bus_if.addrb : r_clr_addr;
    assign w_wdata = w_ready ? bus_if.dinb  : '0;
    assign w_rea   = w_ready & bus_if.rea;
    assign w_reb   = w_ready & bus_if.reb;

    dual_port_ram_core #(
        .DPW (DPW),
        .DW  (DW)
    ) u_core (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_we    (w_we),
        .i_be    (w_be),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_rea   (w_rea),
        .i_addra (bus_if.addra),
        .i_reb   (w_reb),
        .i_addrb (bus_if.addrb),
        .o_qa    (w_qa),
        .o_qb    (w_qb)
    );

    assign w_fwd_hit = (FWD != 0) && w_rea && bus_if.web && (bus_if.addra == bus_if.addrb);

    // Forwarding state only moves with a port A read so a held douta keeps its merged value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fwd_hit  <= 1'b0;
            r_fwd_data <= '0;
            r_fwd_be   <= '0;
            r_valida1  <= 1'b0;
            r_validb1  <= 1'b0;
        end else begin
            r_valida1 <= w_rea;
            r_validb1 <= w_reb;
            if (w_rea) begin
                r_fwd_hit  <= w_fwd_hit;
                r_fwd_data <= bus_if.dinb;
                r_fwd_be   <= bus_if.beb;
            end
        end
    end

    for (genvar k = 0; k < BEW; k++) begin : g_merge
        assign w_qa_merged[8*k +: 8] = be_merge(w_qa[8*k +: 8], r_fwd_data[8*k +: 8], r_fwd_be[k]);
    end

    assign w_douta_s1 = r_fwd_hit ? w_qa_merged : w_qa;

    generate
        if (OREG != 0) begin : g_oreg
            logic [DW-1:0] r_douta2;
            logic [DW-1:0] r_doutb2;
            logic          r_valida2;
            logic          r_validb2;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_douta2  <= '0;
                    r_doutb2  <= '0;
                    r_valida2 <= 1'b0;
                    r_validb2 <= 1'b0;
                end else begin
                    r_valida2 <= r_valida1;
                    r_validb2 <= r_validb1;
                    if (r_valida1) begin
                        r_douta2 <= w_douta_s1;
                    end
                    if (r_validb1) begin
                        r_doutb2 <= w_qb;
                    end
                end
            end

            assign bus_if.douta  = r_douta2;
            assign bus_if.doutb  = r_doutb2;
            assign bus_if.valida = r_valida2;
            assign bus_if.validb = r_validb2;
        end else begin : g_noreg
            assign bus_if.douta  = w_douta_s1;
            assign bus_if.doutb  = w_qb;
            assign bus_if.valida = r_valida1;
            assign bus_if.validb = r_validb1;
        end
    endgenerate

    assign bus_if.init_busy = ~w_ready;
    assign bus_if.init_done = r_init_done;

endmodule

// File: tb/tb_dual_port_ram_ctrl.sv
// Bench for dual_port_ram_ctrl: two instances (OREG=0/FWD=1 and OREG=1/FWD=0) driven in lockstep.
module tb_dual_port_ram_ctrl;
    localparam int DPW = 4;
    localparam int DW  = 32;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        logic        rea;
        logic [3:0]  addra;
        logic        web;
        logic [3:0]  beb;
        logic [3:0]  addrb;
        logic [31:0] dinb;
        logic        reb;
        logic [31:0] expA0;
        logic [31:0] expA1;
        logic [31:0] expB;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   nChecks = 0;
    int   nFails  = 0;
    bit   monEn   = 1'b0;
    exp_t sq[4][$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    dual_port_ram_ctrl_if #(.DPW(DPW), .DW(DW)) if0 ();
    dual_port_ram_ctrl_if #(.DPW(DPW), .DW(DW)) if1 ();

    dual_port_ram_ctrl #(.DPW(DPW), .DW(DW), .OREG(0), .FWD(1)) u_dut0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (if0)
    );

    dual_port_ram_ctrl #(.DPW(DPW), .DW(DW), .OREG(1), .FWD(0)) u_dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (if1)
    );

    function automatic string portName(input int p);
        case (p)
            0:       return "dut0.portA";
            1:       return "dut0.portB";
            2:       return "dut1.portA";
            default: return "dut1.portB";
        endcase
    endfunction

    function automatic vec_t mk(input logic rea, input logic [3:0] aa, input logic web,
                                input logic [3:0] be, input logic [3:0] ab, input logic [31:0] din,
                                input logic reb, input logic [31:0] ea0, input logic [31:0] ea1,
                                input logic [31:0] eb);
        vec_t v;
        v.rea = rea; v.addra = aa; v.web = web; v.beb = be; v.addrb = ab;
        v.dinb = din; v.reb = reb; v.expA0 = ea0; v.expA1 = ea1; v.expB = eb;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        nChecks++;
        if (act !== req) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Pops the scoreboard for one read port and checks both data and arrival cycle.
    task automatic checkPort(input int p, input logic v, input logic [31:0] d);
        exp_t e;
        if (v) begin
            nChecks++;
            if (sq[p].size() == 0) begin
                nFails++;
                $display("[TB] FAIL %s unexpected valid: got data %h at cycle %0d, required no valid", portName(p), d, cyc);
            end else begin
                e = sq[p].pop_front();
                if (e.due != cyc || d !== e.data) begin
                    nFails++;
                    $display("[TB] FAIL %s read: got %h at cycle %0d, required %h at cycle %0d", portName(p), d, cyc, e.data, e.due);
                end
            end
        end else if (sq[p].size() > 0 && sq[p][0].due <= cyc) begin
            e = sq[p].pop_front();
            nChecks++;
            nFails++;
            $display("[TB] FAIL %s missing valid: got none at cycle %0d, required %h", portName(p), cyc, e.data);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && monEn) begin
            checkPort(0, if0.valida, if0.douta);
            checkPort(1, if0.validb, if0.doutb);
            checkPort(2, if1.valida, if1.douta);
            checkPort(3, if1.validb, if1.doutb);
        end
    end

    task automatic setBus(input logic rea, input logic [3:0] aa, input logic web, input logic [3:0] be,
                          input logic [3:0] ab, input logic [31:0] din, input logic reb, input logic ireq);
        if0.rea = rea; if0.addra = aa; if0.web = web; if0.beb = be;
        if0.addrb = ab; if0.dinb = din; if0.reb = reb; if0.init_req = ireq;
        if1.rea = rea; if1.addra = aa; if1.web = web; if1.beb = be;
        if1.addrb = ab; if1.dinb = din; if1.reb = reb; if1.init_req = ireq;
    endtask

    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        setBus(v.rea, v.addra, v.web, v.beb, v.addrb, v.dinb, v.reb, 1'b0);
        if (v.rea) begin
            sq[0].push_back('{due: cyc + 1, data: v.expA0});
            sq[2].push_back('{due: cyc + 2, data: v.expA1});
        end
        if (v.reb) begin
            sq[1].push_back('{due: cyc + 1, data: v.expB});
            sq[3].push_back('{due: cyc + 2, data: v.expB});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(mk(1'b0, 4'd0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0));
        end
    endtask

    task automatic reqInit();
        @(negedge clk);
        setBus(1'b0, 4'd0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 1'b1);
    endtask

    // Samples a fixed window starting in the current cycle; junk requests are driven only while busy.
    task automatic measureClear(input string tag, input int doneIdx, input bit junk);
        int busyCnt, doneCnt, doneAt;
        busyCnt = 0; doneCnt = 0; doneAt = -1;
        for (int i = 0; i < 30; i++) begin
            if (i > 0) @(negedge clk);
            if (if0.init_busy) busyCnt++;
            if (if0.init_done) begin
                doneCnt++;
                doneAt = i;
            end
            if (i > 0) begin
                if (junk && if0.init_busy)
                    setBus(1'b1, 4'd7, 1'b1, 4'hF, 4'd7, 32'h12345678, 1'b1, 1'b0);
                else
                    setBus(1'b0, 4'd0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 1'b0);
            end
        end
        checkOutput({tag, " busy cycles"}, 32'(busyCnt), 32'd16);
        checkOutput({tag, " done pulses"}, 32'(doneCnt), 32'd1);
        checkOutput({tag, " done position"}, 32'(doneAt), 32'(doneIdx));
        checkOutput({tag, " dut1 busy after clear"}, 32'(if1.init_busy), 32'd0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " dut0 douta"}, if0.douta, 32'h0);
        checkOutput({tag, " dut0 doutb"}, if0.doutb, 32'h0);
        checkOutput({tag, " dut0 valida"}, 32'(if0.valida), 32'd0);
        checkOutput({tag, " dut0 validb"}, 32'(if0.validb), 32'd0);
        checkOutput({tag, " dut0 init_busy"}, 32'(if0.init_busy), 32'd1);
        checkOutput({tag, " dut0 init_done"}, 32'(if0.init_done), 32'd0);
        checkOutput({tag, " dut1 douta"}, if1.douta, 32'h0);
        checkOutput({tag, " dut1 doutb"}, if1.doutb, 32'h0);
        checkOutput({tag, " dut1 valida"}, 32'(if1.valida), 32'd0);
        checkOutput({tag, " dut1 init_busy"}, 32'(if1.init_busy), 32'd1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // rea, addra, web, beb, addrb, dinb, reb, douta (FWD=1), douta (FWD=0), doutb
        vecs.push_back(mk(1'b0, 4'd0, 1'b1, 4'hF, 4'd3, 32'hDEADBEEF, 1'b0, 32'h0, 32'h0, 32'h0));
        vecs.push_back(mk(1'b0, 4'd0, 1'b1, 4'h1, 4'd3, 32'h00000011, 1'b0, 32'h0, 32'h0, 32'h0));
        vecs.push_back(mk(1'b1, 4'd3, 1'b0, 4'h0, 4'd3, 32'h0, 1'b1, 32'hDEADBE11, 32'hDEADBE11, 32'hDEADBE11));
        vecs.push_back(mk(1'b0, 4'd0, 1'b1, 4'hF, 4'd5, 32'hAAAAAAAA, 1'b0, 32'h0, 32'h0, 32'h0));
        vecs.push_back(mk(1'b1, 4'd5, 1'b1, 4'h3, 4'd5, 32'h12345678, 1'b1, 32'hAAAA5678, 32'hAAAAAAAA, 32'hAAAAAAAA));
        vecs.push_back(mk(1'b1, 4'd5, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 32'hAAAA5678, 32'hAAAA5678, 32'h0));
        vecs.push_back(mk(1'b0, 4'd0, 1'b1, 4'h0, 4'd9, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h0, 32'h0));
        vecs.push_back(mk(1'b1, 4'd9, 1'b0, 4'h0, 4'd9, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0));
        vecs.push_back(mk(1'b0, 4'd0, 1'b1, 4'hF, 4'd1, 32'h11111111, 1'b0, 32'h0, 32'h0, 32'h0));
        vecs.push_back(mk(1'b0, 4'd0, 1'b1, 4'hF, 4'd2, 32'h22222222, 1'b0, 32'h0, 32'h0, 32'h0));
        vecs.push_back(mk(1'b1, 4'd1, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 32'h11111111, 32'h11111111, 32'h0));
        vecs.push_back(mk(1'b1, 4'd2, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 32'h22222222, 32'h22222222, 32'h0));
        vecs.push_back(mk(1'b1, 4'd3, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 32'hDEADBE11, 32'hDEADBE11, 32'h0));
        vecs.push_back(mk(1'b1, 4'd7, 1'b1, 4'hF, 4'd7, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 32'h0, 32'h0));
        vecs.push_back(mk(1'b1, 4'd4, 1'b1, 4'hC, 4'd4, 32'hCAFE1234, 1'b0, 32'hCAFE0000, 32'h0, 32'h0));
        vecs.push_back(mk(1'b1, 4'd7, 1'b0, 4'h0, 4'd4, 32'h0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hCAFE0000));
        vecs.push_back(mk(1'b1, 4'd5, 1'b0, 4'h0, 4'd5, 32'h0, 1'b1, 32'hAAAA5678, 32'hAAAA5678, 32'hAAAA5678));
        vecs.push_back(mk(1'b1, 4'd6, 1'b1, 4'hF, 4'd8, 32'h88888888, 1'b0, 32'h0, 32'h0, 32'h0));
        vecs.push_back(mk(1'b1, 4'd8, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 32'h88888888, 32'h88888888, 32'h0));

        setBus(1'b0, 4'd0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checkResetState("power-on reset");

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        monEn = 1'b1;
        measureClear("reset clear", 16, 1'b0);

        for (int a = 0; a < 16; a++) begin
            applyStimulus(mk(1'b1, 4'(a), 1'b0, 4'h0, 4'(15 - a), 32'h0, 1'b1, 32'h0, 32'h0, 32'h0));
        end
        idle(3);

        foreach (vecs[i]) applyStimulus(vecs[i]);
        idle(4);

        checkOutput("dut0 douta hold", if0.douta, 32'h88888888);
        checkOutput("dut1 douta hold", if1.douta, 32'h88888888);
        checkOutput("dut0 doutb hold", if0.doutb, 32'hAAAA5678);
        checkOutput("dut1 doutb hold", if1.doutb, 32'hAAAA5678);

        applyStimulus(mk(1'b0, 4'd0, 1'b1, 4'hF, 4'd2, 32'h5A5A5A5A, 1'b0, 32'h0, 32'h0, 32'h0));
        applyStimulus(mk(1'b1, 4'd2, 1'b0, 4'h0, 4'd2, 32'h0, 1'b1, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h5A5A5A5A));
        idle(3);

        reqInit();
        measureClear("init_req clear", 17, 1'b1);
        applyStimulus(mk(1'b1, 4'd7, 1'b0, 4'h0, 4'd2, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0));
        applyStimulus(mk(1'b0, 4'd0, 1'b1, 4'hF, 4'd2, 32'h5A5A5A5A, 1'b0, 32'h0, 32'h0, 32'h0));
        applyStimulus(mk(1'b1, 4'd2, 1'b0, 4'h0, 4'd2, 32'h0, 1'b1, 32'h5A5A5A5A, 32'h5A5A5A5A, 32'h5A5A5A5A));
        idle(3);

        reqInit();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            setBus(1'b0, 4'd0, 1'b0, 4'h0, 4'd0, 32'h0, 1'b0, 1'b0);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checkResetState("mid-clear reset");
        @(negedge clk);
        rst_n = 1'b1;
        measureClear("restarted clear", 16, 1'b0);

        applyStimulus(mk(1'b1, 4'd2, 1'b0, 4'h0, 4'd7, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0));
        idle(4);

        for (int p = 0; p < 4; p++) begin
            if (sq[p].size() != 0) begin
                nChecks++;
                nFails++;
                $display("[TB] FAIL %s drain: got %0d outstanding reads, required 0", portName(p), sq[p].size());
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/dual_port_ram_ctrl.md
Name: dual_port_ram_ctrl

Overview:
Parametrised successor to the team's simple dual-port RAM. Single clock: port A read-only, port B read/write with byte enables. Adds read-valid flags, an optional output register stage, configurable A-side write-to-read forwarding, and a hardware clear engine that zeroes the array after reset or on request. Used as the storage backend for CAM entry/match tables, where synthesis drops initial blocks.

Parameters:
DPW, 10, address width; depth = 2**DPW words
DW, 32, data width; must be a multiple of 8 (elaboration error otherwise)
OREG, 0, 0 = read latency 1 cycle; 1 = extra output register, latency 2
FWD, 1, 1 = port A read of an address B writes in the same cycle returns the new data; 0 = returns the old data

Ports:
clk  in  1  single clock
rst_n  in  1  asynchronous, active-low reset
init_req  in  1  pulse: start a full clear when ready
init_busy  out  1  clear in progress; all requests ignored
init_done  out  1  one-cycle pulse when a clear completes
rea  in  1  port A read enable
addra  in  DPW  port A address
douta  out  DW  port A read data
valida  out  1  douta updated this cycle
web  in  1  port B write enable
beb  in  DW/8  port B byte enables; bit k covers dinb[8k+7:8k]
addrb  in  DPW  port B address
dinb  in  DW  port B write data
reb  in  1  port B read enable
doutb  out  DW  port B read data
validb  out  1  doutb updated this cycle

Behaviour:
- Reset, asynchronous: douta, doutb, valida, validb, init_done = 0; init_busy = 1; FSM enters CLEAR with clr_addr = 0. Array contents are not reset directly.
- FSM CLEAR:
  - Each cycle writes 0 to word clr_addr, then clr_addr += 1.
  - When clr_addr == 2**DPW-1 is written, go to READY next cycle, init_busy = 0 and init_done = 1 for exactly one cycle.
  - A clear takes 2**DPW cycles.
  - rea, reb and web are ignored; valids stay 0.
  - init_req is ignored.
- FSM READY:
  - init_req = 1 sends the FSM to CLEAR with clr_addr = 0. Any request in that same cycle is still served.
  - rst_n asserted at any time, including mid-clear, restarts the clear from 0.
- Write: when web = 1 in READY, byte k of word addrb takes dinb byte k only where beb[k] = 1. web = 1 with beb = 0 changes nothing.
- Read latency:
  - OREG = 0: data is presented the cycle after the request, with valid = 1 in that cycle.
  - OREG = 1: one further cycle of delay; the valid flag is pipelined identically.
- When no read is issued, douta and doutb hold their last value and the valid flag is 0.
- Port A vs B collision (rea and web in the same cycle, addra == addrb):
  - FWD = 1: douta is the merged word, i.e. new bytes where beb is set, old bytes elsewhere.
  - FWD = 0: douta is the old word.
- Port B read with its own write to the same address is always read-first: doutb returns the old word.
- A and B reading the same address simultaneously: both return the same data.
- Addresses wrap naturally. There are no out-of-range accesses.

Decomposition:
- Package dpram_pkg:
  - state enum ST_CLEAR / ST_READY
  - function for byte-enable merge (old, new, be)
  - localparam helper for BEW = DW/8
- One sub-module, dual_port_ram_core:
  - storage array, byte-enable write port, two read-first registered read ports
  - no reset on the array
- The top level holds the FSM, clear counter, write mux (clear vs port B), forwarding compare/merge, OREG stage and valid pipeline.

Test Plan (DPW = 4, DW = 32):
- Reset release -> init_busy high for exactly 16 cycles, then init_done pulses once; reading addresses 0..15 on both ports returns 0, valid 1 cycle after rea/reb.
- Write 0xDEADBEEF at address 3 with beb = 4'b1111, then beb = 4'b0001 with 0x00000011 -> read at address 3 returns 0xDEADBE11.
- Same cycle: web at address 5 (old 0xAAAAAAAA, din 0x12345678, beb = 4'b0011) and rea at address 5 -> FWD = 1: douta = 0xAAAA5678; FWD = 0: douta = 0xAAAAAAAA; doutb (with reb) = 0xAAAAAAAA.
- OREG = 1: rea at cycle t -> valida = 1 and data correct at t+2; back-to-back reads at addresses 1, 2, 3 stream out on consecutive cycles.
- init_req after filling address 7 with 0xFFFFFFFF -> 16 busy cycles; rea/web issued during busy have no effect and valida stays 0; afterwards address 7 reads 0.
- rst_n pulsed low at clear cycle 8 -> outputs 0 immediately; a fresh full 16-cycle clear follows, with one init_done pulse.
